// File: rtl/star_split_if.sv
// AXI-Stream style channel used on the chained input and on both outputs of the ring splitter.
// The master drives data/valid/last and the slave drives ready.
interface star_split_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/star_split.sv
// Ring-node packet splitter: steers each chained packet to the local sink, onward, or both (broadcast).
// Both outputs are fed from independent 2-entry buffers, so output ready never reaches in.TREADY combinationally.
module star_split #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 8,
    parameter int DEST_LSB   = 56,
    parameter int NODE_ID    = 0,
    parameter int BCAST_EN   = 0
) (
    input  logic          clk,
    input  logic          rst,
    star_split_if.slave   in,
    star_split_if.master  loc,
    star_split_if.master  nxt,
    output logic [15:0]   loc_pkts
);

    localparam logic [DEST_WIDTH-1:0] NODE_ADDR = DEST_WIDTH'(NODE_ID);

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_LOC = 2'd1,
        ST_FWD = 2'd2,
        ST_BC  = 2'd3
    } state_e;

    state_e                state_q, state_d, route_s;
    logic [DEST_WIDTH-1:0] hdr_s;
    logic                  in_ready_s;
    logic                  acc_s;
    logic [1:0]            wr_s, rd_s, valid_s, space_s, ready_s;
    logic [1:0]            cnt_q    [2];
    logic                  wr_ptr_q [2];
    logic                  rd_ptr_q [2];
    logic [DATA_WIDTH:0]   ent_q    [2][2];
    logic [15:0]           pkts_q;

    // Local address wins over broadcast when the node itself is all-ones.
    function automatic state_e decode_f(input logic [DEST_WIDTH-1:0] hdr);
        state_e r;
        if (hdr == NODE_ADDR) begin
            r = ST_LOC;
        end else if ((BCAST_EN != 0) && (hdr == {DEST_WIDTH{1'b1}})) begin
            r = ST_BC;
        end else begin
            r = ST_FWD;
        end
        return r;
    endfunction

    assign hdr_s   = in.TDATA[DEST_LSB +: DEST_WIDTH];
    assign ready_s = {nxt.TREADY, loc.TREADY};

    // Route for the present flit: decoded live on a header, frozen otherwise.
    always_comb begin
        route_s = state_q;
        if (state_q == ST_HDR) begin
            route_s = decode_f(hdr_s);
        end else begin
            route_s = state_q;
        end
    end

    // Input ready from buffer occupancy only; broadcast needs room on both sides.
    always_comb begin
        in_ready_s = 1'b0;
        case (route_s)
            ST_LOC:  in_ready_s = space_s[0];
            ST_FWD:  in_ready_s = space_s[1];
            ST_BC:   in_ready_s = space_s[0] & space_s[1];
            default: in_ready_s = 1'b0;
        endcase
    end

    assign in.TREADY = rst & in_ready_s;
    assign acc_s     = in.TVALID & in.TREADY;

    // Buffer write enables for the accepted flit.
    always_comb begin
        wr_s = 2'b00;
        if (acc_s) begin
            case (route_s)
                ST_LOC:  wr_s = 2'b01;
                ST_FWD:  wr_s = 2'b10;
                ST_BC:   wr_s = 2'b11;
                default: wr_s = 2'b00;
            endcase
        end else begin
            wr_s = 2'b00;
        end
    end

    // Next packet state: adopt the route on a header, return to HDR on any accepted last flit.
    always_comb begin
        state_d = state_q;
        if (acc_s) begin
            if (in.TLAST) begin
                state_d = ST_HDR;
            end else begin
                state_d = route_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Packet state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Index 0 feeds loc, index 1 feeds nxt.
    for (genvar g = 0; g < 2; g++) begin : g_buf
        assign valid_s[g] = (cnt_q[g] != 2'd0);
        assign space_s[g] = (cnt_q[g] != 2'd2);
        assign rd_s[g]    = valid_s[g] & ready_s[g];

        // Two-entry circular buffer: occupancy, pointers and storage.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q[g]    <= 2'd0;
                wr_ptr_q[g] <= 1'b0;
                rd_ptr_q[g] <= 1'b0;
                ent_q[g][0] <= '0;
                ent_q[g][1] <= '0;
            end else begin
                case ({wr_s[g], rd_s[g]})
                    2'b10:   cnt_q[g] <= cnt_q[g] + 2'd1;
                    2'b01:   cnt_q[g] <= cnt_q[g] - 2'd1;
                    default: cnt_q[g] <= cnt_q[g];
                endcase
                if (wr_s[g]) begin
                    ent_q[g][wr_ptr_q[g]] <= {in.TLAST, in.TDATA};
                    wr_ptr_q[g]           <= ~wr_ptr_q[g];
                end
                if (rd_s[g]) begin
                    rd_ptr_q[g] <= ~rd_ptr_q[g];
                end
            end
        end
    end

    assign loc.TVALID              = valid_s[0];
    assign {loc.TLAST, loc.TDATA}  = ent_q[0][rd_ptr_q[0]];
    assign nxt.TVALID              = valid_s[1];
    assign {nxt.TLAST, nxt.TDATA}  = ent_q[1][rd_ptr_q[1]];

    // Count packets completed on the local output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkts_q <= 16'd0;
        end else if (rd_s[0] && loc.TLAST) begin
            pkts_q <= pkts_q + 16'd1;
        end else begin
            pkts_q <= pkts_q;
        end
    end

    assign loc_pkts = pkts_q;

endmodule

// File: tb/tb_star_split.sv
// Directed bench for star_split (NODE_ID=3, broadcast enabled); output monitors pop a scoreboard fed by the driver.
module tb_star_split;
    localparam int DW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] loc_pkts;

    always #5 clk = ~clk;

    star_split_if #(.DATA_WIDTH(DW)) in_if ();
    star_split_if #(.DATA_WIDTH(DW)) loc_if ();
    star_split_if #(.DATA_WIDTH(DW)) nxt_if ();

    star_split #(
        .DATA_WIDTH(DW), .DEST_WIDTH(8), .DEST_LSB(56), .NODE_ID(3), .BCAST_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .in(in_if), .loc(loc_if), .nxt(nxt_if), .loc_pkts(loc_pkts)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW:0]   exp_loc[$];
    logic [DW:0]   exp_nxt[$];
    bit            m_mid = 1'b0;
    logic [1:0]    m_route = 2'b00;
    time           t_a, t_b;

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] dest, input logic [55:0] pay);
        return {dest, pay};
    endfunction

    // Reference routing: decode on a header, reuse the route until the last flit.
    task automatic model_accept(input logic [63:0] d, input logic l);
        if (!m_mid) begin
            case (d[63:56])
                8'h03:   m_route = 2'b01;
                8'hFF:   m_route = 2'b11;
                default: m_route = 2'b10;
            endcase
        end
        if (m_route[0]) exp_loc.push_back({l, d});
        if (m_route[1]) exp_nxt.push_back({l, d});
        m_mid = !l;
    endtask

    task automatic present(input logic [63:0] d, input logic l);
        in_if.TDATA  = d;
        in_if.TLAST  = l;
        in_if.TVALID = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        bit done = 1'b0;
        int budget = 0;
        while (!done && budget < 50) begin
            @(negedge clk);
            if (in_if.TREADY) begin
                model_accept(in_if.TDATA, in_if.TLAST);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s: accept timeout got 0 expected 1", name);
        end
        in_if.TVALID = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic l, input string name);
        present(d, l);
        wait_accept(name);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Local output monitor.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst === 1'b1 && loc_if.TVALID && loc_if.TREADY) begin
            if (exp_loc.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL loc_unexpected: got %0h expected none", {loc_if.TLAST, loc_if.TDATA});
            end else begin
                e = exp_loc.pop_front();
                chk("loc_flit", {loc_if.TLAST, loc_if.TDATA}, e);
            end
        end
    end

    // Forwarded output monitor.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst === 1'b1 && nxt_if.TVALID && nxt_if.TREADY) begin
            if (exp_nxt.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL nxt_unexpected: got %0h expected none", {nxt_if.TLAST, nxt_if.TDATA});
            end else begin
                e = exp_nxt.pop_front();
                chk("nxt_flit", {nxt_if.TLAST, nxt_if.TDATA}, e);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        in_if.TVALID  = 1'b0;
        in_if.TDATA   = '0;
        in_if.TLAST   = 1'b0;
        loc_if.TREADY = 1'b1;
        nxt_if.TREADY = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_loc_valid", loc_if.TVALID, 1'b0);
        chk("rst_nxt_valid", nxt_if.TVALID, 1'b0);
        chk("rst_in_ready", in_if.TREADY, 1'b0);
        chk("rst_loc_pkts", loc_pkts, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Local 4-flit packet, one flit per cycle, first output one cycle after accept.
        send(mk(8'h03, 56'h11), 1'b0, "loc_f0");
        t_a = $time;
        chk("loc_latency", loc_if.TVALID, 1'b1);
        send(mk(8'h00, 56'h12), 1'b0, "loc_f1");
        send(mk(8'h00, 56'h13), 1'b0, "loc_f2");
        send(mk(8'h00, 56'h14), 1'b1, "loc_f3");
        t_b = $time;
        chk("loc_throughput", t_b - t_a, 65'd30);
        chk("loc_nxt_idle", nxt_if.TVALID, 1'b0);
        idle(3);
        chk("loc_pkts_1", loc_pkts, 16'd1);

        // Forwarded packet whose second flit looks like a local header.
        send(mk(8'h05, 56'h21), 1'b0, "fwd_f0");
        send(mk(8'h03, 56'h22), 1'b0, "fwd_f1");
        send(mk(8'h00, 56'h23), 1'b1, "fwd_f2");
        idle(3);
        chk("fwd_loc_pkts", loc_pkts, 16'd1);

        // Single-flit local packet immediately followed by a forwarded packet.
        send(mk(8'h03, 56'h31), 1'b1, "b2b_single");
        t_a = $time;
        send(mk(8'h09, 56'h32), 1'b0, "b2b_f0");
        t_b = $time;
        chk("b2b_gap", t_b - t_a, 65'd10);
        send(mk(8'h00, 56'h33), 1'b1, "b2b_f1");
        idle(3);
        chk("b2b_loc_pkts", loc_pkts, 16'd2);

        // Fill loc while stalled, then stream a forwarded packet past it.
        loc_if.TREADY = 1'b0;
        send(mk(8'h03, 56'h41), 1'b0, "hold_f0");
        send(mk(8'h00, 56'h42), 1'b1, "hold_f1");
        send(mk(8'h09, 56'h43), 1'b0, "pass_f0");
        send(mk(8'h00, 56'h44), 1'b0, "pass_f1");
        send(mk(8'h00, 56'h45), 1'b1, "pass_f2");
        idle(2);
        chk("hold_loc_valid", loc_if.TVALID, 1'b1);
        chk("hold_loc_data", loc_if.TDATA, mk(8'h03, 56'h41));
        chk("hold_loc_last", loc_if.TLAST, 1'b0);
        loc_if.TREADY = 1'b1;
        idle(4);
        chk("hold_loc_pkts", loc_pkts, 16'd3);

        // Broadcast with nxt stalled: a further broadcast flit must wait for both buffers.
        nxt_if.TREADY = 1'b0;
        send(mk(8'hFF, 56'h51), 1'b0, "bc_f0");
        send(mk(8'h00, 56'h52), 1'b1, "bc_f1");
        present(mk(8'hFF, 56'h53), 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("bc_full_ready", in_if.TREADY, 1'b0);
            @(posedge clk);
            #1;
        end
        nxt_if.TREADY = 1'b1;
        wait_accept("bc_single");
        idle(5);
        chk("bc_loc_pkts", loc_pkts, 16'd5);

        // Reset in the middle of a local packet.
        loc_if.TREADY = 1'b0;
        send(mk(8'h03, 56'h61), 1'b0, "rst_f0");
        send(mk(8'h00, 56'h62), 1'b0, "rst_f1");
        rst = 1'b0;
        #1;
        chk("mid_rst_loc_valid", loc_if.TVALID, 1'b0);
        chk("mid_rst_nxt_valid", nxt_if.TVALID, 1'b0);
        chk("mid_rst_in_ready", in_if.TREADY, 1'b0);
        chk("mid_rst_loc_pkts", loc_pkts, 16'd0);
        exp_loc.delete();
        exp_nxt.delete();
        m_mid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        loc_if.TREADY = 1'b1;
        send(mk(8'h09, 56'h63), 1'b1, "post_rst_hdr");
        idle(4);
        chk("post_rst_loc_pkts", loc_pkts, 16'd0);

        idle(5);
        chk("loc_queue_empty", exp_loc.size(), 65'd0);
        chk("nxt_queue_empty", exp_nxt.size(), 65'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
